// File: rtl/seg7_mux_2digit_pkg.sv
// rtl/seg7_mux_2digit_pkg.sv - shared state encodings and segment constants for the 2-digit display mux
package seg7_mux_2digit_pkg;

    // Scan phases in the order they are visited.
    typedef enum logic [1:0] {
        ST_GAP1  = 2'd0,
        ST_SHOW0 = 2'd1,
        ST_GAP0  = 2'd2,
        ST_SHOW1 = 2'd3
    } state_e;

    // Patterns are active-high here. Index 0 is segment a and index 6 is segment g.
    localparam logic [0:6] SEG_ZERO = 7'b1111110;
    localparam logic [0:6] SEG_OFF  = 7'b0000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg7_mux_2digit_if.sv
// rtl/seg7_mux_2digit_if.sv - digit inputs and multiplexed display outputs of the 2-digit mux
interface seg7_mux_2digit_if;
    logic [0:6] digit1;
    logic [0:6] digit0;
    logic       enable;
    logic       blank_lz;
    logic [0:6] seg;
    logic [1:0] an;
    logic       frame_start;

    modport master (
        output digit1, digit0, enable, blank_lz,
        input  seg, an, frame_start
    );

    modport slave (
        input  digit1, digit0, enable, blank_lz,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - phase counter that flags the last cycle of each scan phase
module seg7_scan_timer #(
    parameter int CW = 2
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic [CW:0] phase_len,
    output logic        phase_done
);
    logic [CW-1:0] cnt;

    // The last count of the phase; the FSM advances on the following edge.
    assign phase_done = enable && ({1'b0, cnt} == (phase_len - (CW+1)'(1)));

    // Count from zero, clearing on wrap, on a phase change, or while parked.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable || restart || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/seg7_mux_2digit.sv
// rtl/seg7_mux_2digit.sv - time-multiplexes two 7-segment digits with dead-time gaps and frame latching
module seg7_mux_2digit #(
    parameter int SCAN_DIV       = 5000,
    parameter int GAP_CYCLES     = 50,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clkIn,
    input  logic               rst,
    seg7_mux_2digit_if.slave   bus
);
    import seg7_mux_2digit_pkg::*;

    localparam int MAXLEN = max3(SCAN_DIV, GAP_CYCLES, 2);
    localparam int CW     = $clog2(MAXLEN);

    localparam logic [CW:0] SHOW_LEN = (CW+1)'(SCAN_DIV);
    // A zero-length gap is never entered, so its timer length just needs to be legal.
    localparam logic [CW:0] GAP_LEN  = (CW+1)'((GAP_CYCLES == 0) ? 1 : GAP_CYCLES);
    localparam bit          NO_GAP   = (GAP_CYCLES == 0);

    localparam logic [0:6] SEG_BLANK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0] AN_IDLE   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    state_e     state;
    state_e     nxt;
    logic       phase_done;
    logic       restart;
    logic [CW:0] phase_len;
    logic [0:6] shadow1;
    logic [0:6] shadow0;
    logic [0:6] seg_q;
    logic [1:0] an_q;
    logic       fs_q;

    function automatic logic [0:6] seg_drive(input logic [0:6] p);
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    function automatic logic [1:0] an_drive(input logic [1:0] sel);
        return AN_ACTIVE_LOW ? ~sel : sel;
    endfunction

    assign phase_len = (state == ST_SHOW0 || state == ST_SHOW1) ? SHOW_LEN : GAP_LEN;
    assign restart   = (nxt != state);

    seg7_scan_timer #(.CW(CW)) u_timer (
        .clkIn      (clkIn),
        .rst        (rst),
        .enable     (bus.enable),
        .restart    (restart),
        .phase_len  (phase_len),
        .phase_done (phase_done)
    );

    // Next phase; a low enable parks the scan in GAP1 ahead of any wrap.
    always_comb begin
        nxt = state;
        if (!bus.enable) begin
            nxt = ST_GAP1;
        end else begin
            case (state)
                ST_GAP1:  if (NO_GAP || phase_done) nxt = ST_SHOW0;
                ST_SHOW0: if (phase_done) nxt = NO_GAP ? ST_SHOW1 : ST_GAP0;
                ST_GAP0:  if (NO_GAP || phase_done) nxt = ST_SHOW1;
                ST_SHOW1: if (phase_done) nxt = NO_GAP ? ST_SHOW0 : ST_GAP1;
                default:  nxt = ST_GAP1;
            endcase
        end
    end

    // State register, frame latch and registered outputs decoded from the phase being entered.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state   <= ST_GAP1;
            shadow1 <= SEG_OFF;
            shadow0 <= SEG_OFF;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_IDLE;
            fs_q    <= 1'b0;
        end else begin
            state <= nxt;
            seg_q <= SEG_BLANK;
            an_q  <= AN_IDLE;
            fs_q  <= 1'b0;
            case (nxt)
                ST_SHOW0: begin
                    an_q <= an_drive(2'b01);
                    if (state != ST_SHOW0) begin
                        shadow1 <= bus.digit1;
                        shadow0 <= bus.digit0;
                        fs_q    <= 1'b1;
                        seg_q   <= seg_drive(bus.digit0);
                    end else begin
                        seg_q <= seg_drive(shadow0);
                    end
                end
                ST_SHOW1: begin
                    if (!(bus.blank_lz && shadow1 == SEG_ZERO)) begin
                        seg_q <= seg_drive(shadow1);
                        an_q  <= an_drive(2'b10);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_mux_2digit.sv
// tb/tb_seg7_mux_2digit.sv - directed scoreboard bench for seg7_mux_2digit
module tb_seg7_mux_2digit;

    localparam logic [0:6] BLANK = 7'b1111111;
    localparam logic [0:6] D_ZERO  = 7'b1111110;
    localparam logic [0:6] D_ONE   = 7'b0110000;
    localparam logic [0:6] D_TWO   = 7'b1101101;
    localparam logic [0:6] D_THREE = 7'b1111001;

    typedef struct {
        bit         dut_b;
        logic [0:6] seg;
        logic [1:0] an;
        logic       fs;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    seg7_mux_2digit_if bus_a ();
    seg7_mux_2digit_if bus_b ();

    assign bus_b.digit1   = bus_a.digit1;
    assign bus_b.digit0   = bus_a.digit0;
    assign bus_b.enable   = bus_a.enable;
    assign bus_b.blank_lz = bus_a.blank_lz;

    seg7_mux_2digit #(.SCAN_DIV(4), .GAP_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clkIn (clk),
        .rst   (rst),
        .bus   (bus_a)
    );

    seg7_mux_2digit #(.SCAN_DIV(4), .GAP_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_b (
        .clkIn (clk),
        .rst   (rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic push(input bit b, input logic [0:6] s, input logic [1:0] a, input logic f, input string tag);
        exp_t e;
        e.dut_b = b;
        e.seg   = s;
        e.an    = a;
        e.fs    = f;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t       e;
        logic [0:6] s;
        logic [1:0] a;
        logic       f;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard: empty queue, nothing expected");
        end else begin
            e = sb.pop_front();
            s = e.dut_b ? bus_b.seg : bus_a.seg;
            a = e.dut_b ? bus_b.an : bus_a.an;
            f = e.dut_b ? bus_b.frame_start : bus_a.frame_start;
            assert ({s, a, f} === {e.seg, e.an, e.fs}) else begin
                miscompares++;
                $error("FAIL %s: seg/an/frame_start observed %b/%b/%b expected %b/%b/%b",
                       e.tag, s, a, f, e.seg, e.an, e.fs);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected display of the 10-cycle frame (SCAN_DIV=4, GAP=1) on DUT A, cycles k0..kend-1,
    // with k=0 being the edge that enters SHOW0. Digits may be changed before edge chg_at.
    task automatic run_frame(input logic [0:6] sh1, input logic [0:6] sh0, input bit lzb,
                             input int k0, input int kend, input int chg_at,
                             input logic [0:6] n1, input logic [0:6] n0, input string tag);
        for (int k = k0; k < kend; k++) begin
            if (k < 4)
                push(1'b0, ~sh0, 2'b10, (k == 0), tag);
            else if (k == 4 || k == 9)
                push(1'b0, BLANK, 2'b11, 1'b0, tag);
            else if (lzb && sh1 == D_ZERO)
                push(1'b0, BLANK, 2'b11, 1'b0, tag);
            else
                push(1'b0, ~sh1, 2'b01, 1'b0, tag);
            if (k == chg_at) begin
                bus_a.digit1 = n1;
                bus_a.digit0 = n0;
            end
            tick();
            check_one();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus_a.enable   = 1'b1;
        bus_a.blank_lz = 1'b0;
        bus_a.digit1   = D_ONE;
        bus_a.digit0   = D_TWO;

        // Outputs stay dark while reset is held.
        for (int i = 0; i < 3; i++) begin
            tick();
            push(1'b0, BLANK, 2'b11, 1'b0, "reset_hold_a");
            check_one();
            push(1'b1, BLANK, 2'b11, 1'b0, "reset_hold_b");
            check_one();
        end

        // Scan order and period, then tearing protection.
        rst = 1'b1;
        run_frame(D_ONE, D_TWO, 1'b0, 0, 10, -1, D_ONE, D_TWO, "scan");
        run_frame(D_ONE, D_TWO, 1'b0, 0, 10, 6, D_ONE, D_THREE, "tear_hold");
        run_frame(D_ONE, D_THREE, 1'b0, 0, 10, 1, D_ZERO, D_THREE, "tear_next");

        // Leading-zero blanking, then the same zero displayed.
        bus_a.blank_lz = 1'b1;
        run_frame(D_ZERO, D_THREE, 1'b1, 0, 10, -1, D_ZERO, D_THREE, "lz_blank");
        bus_a.blank_lz = 1'b0;
        run_frame(D_ZERO, D_THREE, 1'b0, 0, 10, -1, D_ZERO, D_THREE, "lz_show");

        // Enable dropped in SHOW0, then restored.
        tick();
        push(1'b0, ~D_THREE, 2'b10, 1'b1, "en_show0");
        check_one();
        tick();
        push(1'b0, ~D_THREE, 2'b10, 1'b0, "en_show0b");
        check_one();
        bus_a.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            push(1'b0, BLANK, 2'b11, 1'b0, "en_dark");
            check_one();
        end
        bus_a.enable = 1'b1;
        tick();
        push(1'b0, ~D_THREE, 2'b10, 1'b1, "en_restart");
        check_one();
        run_frame(D_ZERO, D_THREE, 1'b0, 1, 10, -1, D_ZERO, D_THREE, "en_frame");

        // Asynchronous reset in the middle of SHOW1.
        run_frame(D_ZERO, D_THREE, 1'b0, 0, 7, -1, D_ZERO, D_THREE, "pre_reset");
        rst = 1'b0;
        #1;
        push(1'b0, BLANK, 2'b11, 1'b0, "async_reset_a");
        check_one();
        push(1'b1, BLANK, 2'b11, 1'b0, "async_reset_b");
        check_one();

        // Gap-less build: SHOW0/SHOW1 alternate every 4 cycles from the first edge.
        bus_a.digit1 = D_ONE;
        bus_a.digit0 = D_TWO;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if ((k % 8) < 4)
                push(1'b1, ~D_TWO, 2'b10, ((k % 8) == 0), "nogap");
            else
                push(1'b1, ~D_ONE, 2'b01, 1'b0, "nogap");
            tick();
            check_one();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
